datapath_bus: RTL and testbench

Register-file, bus and ALU datapath that carries out the control signals issued by the processor control unit. It decodes `read_en` into a single 16-bit bus source and applies `write_en`, `inc_en` and `clr_en` to its registers. It also updates the zero flag and returns `instruction` and `z` to the control unit. It sits between the control unit and the external instruction and data memories.

---
 rtl/datapath_bus_if.sv | 32 +++
 rtl/datapath_bus.sv | 124 ++++++++++++
 tb/tb_datapath_bus.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/datapath_bus_if.sv
// Control-unit / memory side bundle of the datapath: strobes, ALU op,
// memory ports and observed state returned to the controller.
interface datapath_bus_if #(
  parameter int WIDTH = 16
);
  logic [3:0]       read_en;
  logic [15:0]      write_en;
  logic [15:0]      inc_en;
  logic [15:0]      clr_en;
  logic [2:0]       alu_op;
  logic [WIDTH-1:0] z;
  logic [WIDTH-1:0] instruction;
  logic [WIDTH-1:0] im_addr;
  logic [WIDTH-1:0] im_rdata;
  logic [WIDTH-1:0] dm_addr;
  logic [WIDTH-1:0] dm_wdata;
  logic             dm_we;
  logic [WIDTH-1:0] dm_rdata;
  logic [WIDTH-1:0] bus_out;

  // Controller plus memories drive strobes and read data.
  modport master (
    output read_en, write_en, inc_en, clr_en, alu_op, im_rdata, dm_rdata,
    input  z, instruction, im_addr, dm_addr, dm_wdata, dm_we, bus_out
  );

  // The datapath consumes strobes and returns state.
  modport slave (
    input  read_en, write_en, inc_en, clr_en, alu_op, im_rdata, dm_rdata,
    output z, instruction, im_addr, dm_addr, dm_wdata, dm_we, bus_out
  );
endinterface

// File: rtl/datapath_bus.sv
// Register file, shared bus and ALU executing control-unit strobes.
// Strobe map (write/inc/clr): 1 PC, 2 AR, 3 IR, 4 AC, 5 R, 6 R4, 7 R3,
// 8 R2, 9 R1; write-only extras: 11 DM write, 12 ALU->AC, 13 AC->R.
module datapath_bus #(
  parameter int WIDTH = 16
) (
  input logic           clk,
  input logic           rst,
  datapath_bus_if.slave dbus
);

  logic [WIDTH-1:0]   pc, ar, ir, ac, r, r1, r2, r3, r4;
  logic [WIDTH-1:0]   pc_n, ar_n, ir_n, ac_n, r_n, r1_n, r2_n, r3_n, r4_n;
  logic               z_q;
  logic [WIDTH-1:0]   bus;
  logic [WIDTH-1:0]   alu_y;
  logic [2*WIDTH-1:0] prod;
  logic [15:0]        we, inc, clr;
  logic               unused_strobes;

  assign we  = dbus.write_en;
  assign inc = dbus.inc_en;
  assign clr = dbus.clr_en;

  // Bits with no destination in this datapath (IM is read-only).
  assign unused_strobes = ^{we[0], we[10], we[15:14], inc[0], inc[15:10],
                            clr[0], clr[15:10]};

  // Clear beats write beats increment; otherwise hold.
  function automatic logic [WIDTH-1:0] next_val(
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] d,
    input logic             c,
    input logic             w,
    input logic             i
  );
    if (c)      return '0;
    else if (w) return d;
    else if (i) return cur + WIDTH'(1);
    else        return cur;
  endfunction

  // Bus source decode; reserved codes drive zero.
  always_comb begin
    bus = '0;
    case (dbus.read_en)
      4'd1:    bus = pc;
      4'd2:    bus = ar;
      4'd4:    bus = ir;
      4'd5:    bus = ac;
      4'd6:    bus = r;
      4'd7:    bus = r1;
      4'd8:    bus = r2;
      4'd9:    bus = r3;
      4'd10:   bus = r4;
      4'd12:   bus = dbus.dm_rdata;
      4'd13:   bus = dbus.im_rdata;
      default: bus = '0;
    endcase
  end

  assign prod = {{WIDTH{1'b0}}, ac} * {{WIDTH{1'b0}}, r};

  // ALU on A = AC, B = R; undefined ops pass AC through.
  always_comb begin
    alu_y = ac;
    case (dbus.alu_op)
      3'd1:    alu_y = ac + r;
      3'd2:    alu_y = ac - r;
      3'd3:    alu_y = prod[WIDTH-1:0];
      3'd4:    alu_y = {ac[WIDTH-2:0], 1'b0};
      default: alu_y = ac;
    endcase
  end

  // Next register values; AC->R takes the pre-edge AC, not the bus.
  always_comb begin
    pc_n = next_val(pc, bus, clr[1], we[1], inc[1]);
    ar_n = next_val(ar, bus, clr[2], we[2], inc[2]);
    ir_n = next_val(ir, bus, clr[3], we[3], inc[3]);
    ac_n = next_val(ac, we[12] ? alu_y : bus, clr[4], we[12] | we[4], inc[4]);
    r_n  = next_val(r, we[13] ? ac : bus, clr[5], we[13] | we[5], inc[5]);
    r4_n = next_val(r4, bus, clr[6], we[6], inc[6]);
    r3_n = next_val(r3, bus, clr[7], we[7], inc[7]);
    r2_n = next_val(r2, bus, clr[8], we[8], inc[8]);
    r1_n = next_val(r1, bus, clr[9], we[9], inc[9]);
  end

  // Register file and zero flag; reset overrides all strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc  <= '0;
      ar  <= '0;
      ir  <= '0;
      ac  <= '0;
      r   <= '0;
      r1  <= '0;
      r2  <= '0;
      r3  <= '0;
      r4  <= '0;
      z_q <= 1'b1;
    end else begin
      pc  <= pc_n;
      ar  <= ar_n;
      ir  <= ir_n;
      ac  <= ac_n;
      r   <= r_n;
      r1  <= r1_n;
      r2  <= r2_n;
      r3  <= r3_n;
      r4  <= r4_n;
      z_q <= (ac_n == '0);
    end
  end

  assign dbus.z           = {{(WIDTH-1){1'b0}}, z_q};
  assign dbus.instruction = ir;
  assign dbus.im_addr     = pc;
  assign dbus.dm_addr     = ar;
  assign dbus.dm_wdata    = bus;
  assign dbus.dm_we       = we[11];
  assign dbus.bus_out     = bus;

endmodule

// File: tb/tb_datapath_bus.sv
// Scoreboard bench for datapath_bus: expectations are queued with the
// stimulus and compared once the DUT presents the result.
module tb_datapath_bus;

  localparam int WIDTH = 16;

  // Observation selectors: 0..15 read a register through the bus.
  localparam int S_PC   = 16;
  localparam int S_IR   = 17;
  localparam int S_AR   = 18;
  localparam int S_Z    = 19;
  localparam int S_BUS  = 20;
  localparam int S_DMWE = 21;
  localparam int S_DMWD = 22;

  typedef struct {
    string       tag;
    int          sel;
    logic [15:0] val;
  } exp_t;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;
  exp_t q_now[$];
  exp_t q_post[$];

  datapath_bus_if #(.WIDTH(WIDTH)) dbi ();

  datapath_bus #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .dbus (dbi.slave)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    if (obs !== exp)
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    else
      n_pass++;
  endtask

  function automatic logic [15:0] observe(input int sel);
    case (sel)
      S_PC:    return dbi.im_addr;
      S_IR:    return dbi.instruction;
      S_AR:    return dbi.dm_addr;
      S_Z:     return dbi.z;
      S_DMWE:  return {15'b0, dbi.dm_we};
      S_DMWD:  return dbi.dm_wdata;
      default: return dbi.bus_out;
    endcase
  endfunction

  task automatic exp_now(input string tag, input int sel, input logic [15:0] v);
    exp_t e;
    e.tag = tag; e.sel = sel; e.val = v;
    q_now.push_back(e);
  endtask

  task automatic exp_post(input string tag, input int sel, input logic [15:0] v);
    exp_t e;
    e.tag = tag; e.sel = sel; e.val = v;
    q_post.push_back(e);
  endtask

  // In-cycle checks: inputs stay as driven.
  task automatic drain_now();
    exp_t e;
    while (q_now.size() > 0) begin
      e = q_now.pop_front();
      #1;
      chk(e.tag, observe(e.sel), e.val);
    end
  endtask

  // Post-edge checks: strobes idle, registers read back through the bus.
  task automatic drain_post();
    exp_t e;
    dbi.write_en = '0;
    dbi.inc_en   = '0;
    dbi.clr_en   = '0;
    dbi.alu_op   = '0;
    while (q_post.size() > 0) begin
      e = q_post.pop_front();
      if (e.sel < 16) dbi.read_en = 4'(e.sel);
      #1;
      chk(e.tag, observe(e.sel), e.val);
    end
  endtask

  task automatic step(input logic rst_v, input logic [3:0] re, input logic [15:0] we,
                      input logic [15:0] inc, input logic [15:0] clr, input logic [2:0] op);
    rst          = rst_v;
    dbi.read_en  = re;
    dbi.write_en = we;
    dbi.inc_en   = inc;
    dbi.clr_en   = clr;
    dbi.alu_op   = op;
    #1;
    drain_now();
    @(posedge clk);
    #1;
    rst = 1'b0;
    drain_post();
  endtask

  // Load a value through the instruction-memory bus source.
  task automatic load_im(input logic [15:0] v, input logic [15:0] we);
    dbi.im_rdata = v;
    step(1'b0, 4'd13, we, '0, '0, 3'd0);
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst = 1'b1;
    dbi.read_en  = '0;
    dbi.write_en = '0;
    dbi.inc_en   = '0;
    dbi.clr_en   = '0;
    dbi.alu_op   = '0;
    dbi.im_rdata = '0;
    dbi.dm_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Fill every register, then reset with all strobes asserted.
    exp_post("preload_pc", S_PC, 16'hABCD);
    exp_post("preload_z", S_Z, 16'h0000);
    load_im(16'hABCD, 16'h03FE);
    exp_post("rst_pc", 1, 16'h0000);
    exp_post("rst_ar", 2, 16'h0000);
    exp_post("rst_ir", 4, 16'h0000);
    exp_post("rst_ac", 5, 16'h0000);
    exp_post("rst_r", 6, 16'h0000);
    exp_post("rst_r1", 7, 16'h0000);
    exp_post("rst_r2", 8, 16'h0000);
    exp_post("rst_r3", 9, 16'h0000);
    exp_post("rst_r4", 10, 16'h0000);
    exp_post("rst_z", S_Z, 16'h0001);
    exp_post("rst_instr", S_IR, 16'h0000);
    step(1'b1, 4'd13, 16'hFFFF, 16'hFFFF, 16'hFFFF, 3'd7);

    // Fetch and PC increment.
    exp_post("fetch_ir", S_IR, 16'h0013);
    load_im(16'h0013, 16'h0008);
    exp_post("pc_inc", S_PC, 16'h0001);
    step(1'b0, 4'd0, 16'h0000, 16'h0002, 16'h0000, 3'd0);

    // Load and store.
    exp_post("ac_preset_z", S_Z, 16'h0000);
    load_im(16'h0040, 16'h0010);
    exp_post("dm_addr", S_AR, 16'h0040);
    step(1'b0, 4'd5, 16'h0004, '0, '0, 3'd0);
    dbi.dm_rdata = 16'h1234;
    exp_post("load_ac", 5, 16'h1234);
    exp_post("load_z", S_Z, 16'h0000);
    step(1'b0, 4'd12, 16'h0010, '0, '0, 3'd0);
    exp_now("store_we", S_DMWE, 16'h0001);
    exp_now("store_wdata", S_DMWD, 16'h1234);
    exp_post("store_we_off", S_DMWE, 16'h0000);
    step(1'b0, 4'd5, 16'h0800, '0, '0, 3'd0);

    // ALU operations.
    exp_post("alu_pre_ac", 5, 16'h0007);
    exp_post("alu_pre_r", 6, 16'h0007);
    load_im(16'h0007, 16'h0030);
    exp_post("alu_sub_ac", 5, 16'h0000);
    exp_post("alu_sub_z", S_Z, 16'h0001);
    step(1'b0, 4'd0, 16'h1000, '0, '0, 3'd2);
    load_im(16'h0003, 16'h0020);
    load_im(16'h8001, 16'h0010);
    exp_post("alu_mul_ac", 5, 16'h8003);
    step(1'b0, 4'd0, 16'h1000, '0, '0, 3'd3);
    load_im(16'h8001, 16'h0010);
    exp_post("alu_shl_ac", 5, 16'h0002);
    exp_post("alu_shl_z", S_Z, 16'h0000);
    step(1'b0, 4'd0, 16'h1000, '0, '0, 3'd4);

    // Priorities and wrap.
    dbi.im_rdata = 16'h5555;
    exp_post("pc_clr_wins", S_PC, 16'h0000);
    step(1'b0, 4'd13, 16'h0002, 16'h0002, 16'h0002, 3'd0);
    dbi.im_rdata = 16'h0100;
    exp_post("pc_wr_over_inc", S_PC, 16'h0100);
    step(1'b0, 4'd13, 16'h0002, 16'h0002, 16'h0000, 3'd0);
    load_im(16'hFFFF, 16'h0002);
    exp_post("pc_wrap", S_PC, 16'h0000);
    step(1'b0, 4'd0, 16'h0000, 16'h0002, 16'h0000, 3'd0);
    exp_post("ac_ffff_z", S_Z, 16'h0000);
    load_im(16'hFFFF, 16'h0010);
    exp_post("ac_wrap", 5, 16'h0000);
    exp_post("ac_wrap_z", S_Z, 16'h0001);
    step(1'b0, 4'd0, 16'h0000, 16'h0010, 16'h0000, 3'd0);
    load_im(16'h0005, 16'h0010);
    dbi.im_rdata = 16'h7777;
    exp_post("alu_over_bus", 5, 16'h0008);
    step(1'b0, 4'd13, 16'h1010, '0, '0, 3'd1);
    dbi.im_rdata = 16'h1111;
    exp_post("ac_to_r_old", 6, 16'h0008);
    exp_post("ac_bus_same", 5, 16'h1111);
    step(1'b0, 4'd13, 16'h2030, '0, '0, 3'd0);

    // Register moves and reserved sources.
    load_im(16'hBEEF, 16'h0010);
    exp_post("r1_move", 7, 16'hBEEF);
    step(1'b0, 4'd5, 16'h0200, '0, '0, 3'd0);
    exp_post("ac_clr_z", S_Z, 16'h0001);
    step(1'b0, 4'd0, 16'h0000, '0, 16'h0010, 3'd0);
    exp_post("r1_to_ac", 5, 16'hBEEF);
    exp_post("r1_to_ac_z", S_Z, 16'h0000);
    step(1'b0, 4'd7, 16'h0010, '0, '0, 3'd0);
    exp_now("bus_rsv3", S_BUS, 16'h0000);
    step(1'b0, 4'd3, '0, '0, '0, 3'd0);
    exp_now("bus_rsv11", S_BUS, 16'h0000);
    step(1'b0, 4'd11, '0, '0, '0, 3'd0);
    exp_now("bus_dm", S_BUS, 16'h1234);
    step(1'b0, 4'd12, '0, '0, '0, 3'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
